// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the data-cache controller
// and the instruction refill path, with a lock hint and a watchdog abort.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_lock,
    input  logic [2:0]            d_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_ctrl,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  owner,
    output logic                  timeout_err
);

    localparam logic [2:0] I_MODE = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_D,
        GRANT_I
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last;       // 0 = D served last, 1 = I served last
    logic       lock_d;
    logic [7:0] wd_cnt;
    logic       granted;
    logic       expire;
    logic       done;

    assign granted = (state != IDLE);
    // A mem_ready arriving in the expiry cycle is a normal completion.
    assign expire  = granted && !mem_ready && (wd_cnt == 8'(TIMEOUT));
    assign done    = granted && (mem_ready || expire);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || lock_d || last))
                    state_nxt = GRANT_D;
                else if (i_req)
                    state_nxt = GRANT_I;
            end
            GRANT_D, GRANT_I: begin
                if (done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ctrl  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        d_ready   = 1'b0;
        d_rdata   = '0;
        i_ready   = 1'b0;
        i_rdata   = '0;
        case (state)
            GRANT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_ctrl  = d_mode;
                mem_we    = d_we;
                mem_re    = !d_we;
                d_ready   = done;
                if (mem_ready)
                    d_rdata = mem_rdata;
            end
            GRANT_I: begin
                mem_addr = i_addr;
                mem_ctrl = I_MODE;
                mem_re   = 1'b1;
                i_ready  = done;
                if (mem_ready)
                    i_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign busy  = granted;
    assign owner = (state == GRANT_I);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            lock_d      <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                // A lock survives only one IDLE cycle, whether or not D uses it.
                wd_cnt <= '0;
                lock_d <= 1'b0;
            end else if (done) begin
                last <= (state == GRANT_I);
                if (state == GRANT_D)
                    lock_d <= d_lock;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            if (expire)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single backing data-memory port (the `dataMemCached`-style port with `ready` handshake) between the data-cache controller (refill / write-back / uncached access) and the instruction-fetch refill path. It serialises transactions with round-robin fairness, keeps a data-cache write-back followed by its allocate back-to-back via a lock hint, and aborts hung memory transactions with a watchdog. It sits between the cache FSMs and the memory model, one level below the cache controllers.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `TIMEOUT`, 64, max cycles a granted transaction may wait for `mem_ready`; range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `d_req`  in  1  data-side request, held until `d_ready`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_lock`  in  1  sampled with `d_ready`; 1 = D owns the next arbitration.
- `d_mode`  in  3  access mode, forwarded to `mem_ctrl`.
- `d_addr`  in  ADDR_WIDTH  data-side address.
- `d_wdata`  in  DATA_WIDTH  data-side write data.
- `d_rdata`  out  DATA_WIDTH  read data, valid when `d_ready`.
- `d_ready`  out  1  one-cycle completion pulse.
- `i_req`  in  1  instruction refill request (read only, mode fixed 3'b010 word).
- `i_addr`  in  ADDR_WIDTH  instruction address.
- `i_rdata`  out  DATA_WIDTH  read data, valid when `i_ready`.
- `i_ready`  out  1  one-cycle completion pulse.
- `mem_addr`, `mem_wdata`, `mem_ctrl`, `mem_we`, `mem_re`  out  memory-side command.
- `mem_rdata`  in  DATA_WIDTH; `mem_ready`  in  1  memory completion.
- `busy`  out  1  high in any grant state.
- `owner`  out  1  0 = D, 1 = I; meaningful while `busy`.
- `timeout_err`  out  1  sticky, set on any watchdog abort.

## Operation

- States: IDLE, GRANT_D, GRANT_I. Registers: state, `last` (last granted, 0 = D, 1 = I), `lock_d`, watchdog counter, `timeout_err`.
- IDLE: no req -> stay. One req -> grant it. Both -> if `lock_d`, GRANT_D; else grant the port not equal to `last`. Grant taken on next edge; `lock_d` cleared when leaving IDLE.
- GRANT_x: memory command driven combinationally from granted port's inputs (`mem_re` = !we, `mem_we` = we; I side always read). In IDLE all `mem_*` outputs are 0.
- Completion: `mem_ready` high in GRANT_x -> same cycle `x_ready`=1, `x_rdata`=`mem_rdata`; next state IDLE; `last` <= x; if x = D, `lock_d` <= `d_lock`.
- Watchdog: counter cleared on grant entry, increments each GRANT cycle without `mem_ready`; when it reaches TIMEOUT, pulse `x_ready` with `x_rdata`=0, set `timeout_err`, return to IDLE. A `mem_ready` in the same cycle wins (normal completion, no error).
- `x_rdata` is 0 whenever `x_ready` is 0.
- Requester must keep inputs stable while req high; req still high in IDLE after a completion is a new transaction.

## Timing

- Reset (async, immediate): state IDLE, `last`=1 (D wins first tie), `lock_d`=0, counter 0, `timeout_err`=0; all outputs 0.
- Latency: req seen in IDLE at cycle n -> command on memory at n+1 -> `x_ready` same cycle as `mem_ready` (earliest n+1). One IDLE bubble between transactions: back-to-back throughput is one transaction per 2 cycles minimum.
- Reset mid-transaction: command dropped in the same cycle; no ready pulse; in-flight transaction lost.
- Req dropped while granted: illegal; arbiter keeps the grant until completion/timeout.
- `d_lock` honoured only if `d_req` high in the next IDLE cycle; otherwise lock discarded and normal round-robin applies.

## Test plan

- Reset, D read 0x100, memory ready after 3 cycles returning 0xDEADBEEF -> `mem_re`=1 cycles 1-3, `d_ready` at cycle 3 with `d_rdata`=0xDEADBEEF, IDLE at 4.
- `d_req` and `i_req` rise together after reset, both held -> D granted first, then I, then D (alternation), each `ready` single-cycle.
- D write-back to 0x200 with `d_lock`=1 while `i_req` pending, then D read 0x300 -> D read granted before I; I granted after.
- Memory never asserts ready, TIMEOUT=4 -> `i_ready` pulse with `i_rdata`=0 exactly 4 cycles after grant, `timeout_err`=1 and stays 1 until reset.
- `mem_ready` coincident with watchdog expiry -> normal completion, `timeout_err` remains 0.
- `rst_n` low during GRANT_D -> `mem_we`/`mem_re`/`busy` 0 immediately, no `d_ready`, IDLE after release.
